// File: rtl/hub75_pixel_loader.sv
// HUB75 pixel loader: turns a {R,G,B} pixel stream framed by start-of-frame
// and end-of-line markers into frame buffer writes, checking the framing and
// resynchronising on the next start-of-frame after any framing error.
//
// Stream handshake: a beat transfers on a rising edge where s_valid and
// s_ready are both high; s_ready mirrors i_enable and never waits on s_valid.
module hub75_pixel_loader #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_enable,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [3*bpp_p-1:0]                         s_data,
  input  logic                                       s_sof,
  input  logic                                       s_eol,
  output logic [$clog2(hpixel_p*vpixel_p)-1:0]       o_wr_addr,
  output logic [3*bpp_p-1:0]                         o_wr_data,
  output logic                                       o_wr_en,
  output logic                                       o_frame_done,
  output logic                                       o_err,
  output logic [7:0]                                 o_err_cnt
);

  localparam int addr_width_p = $clog2(hpixel_p*vpixel_p);
  localparam int col_w_p      = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int row_w_p      = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    LOAD     = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [col_w_p-1:0]        col_q, col_d;
  logic [row_w_p-1:0]        row_q, row_d;
  logic [addr_width_p-1:0]   wr_addr_q, wr_addr_d;
  logic [3*bpp_p-1:0]        wr_data_q, wr_data_d;
  logic                      wr_en_q, wr_en_d;
  logic                      frame_done_q, frame_done_d;
  logic                      err_q, err_d;
  logic [7:0]                err_cnt_q, err_cnt_d;

  // Position the beat is written at: a start-of-frame always lands on pixel 0.
  logic [col_w_p-1:0]        eff_col;
  logic [row_w_p-1:0]        eff_row;
  logic                      last_col;
  logic                      last_row;
  logic                      accept;
  logic                      take;

  assign s_ready = i_enable;

  // Next-state, counter and write-port decode for one accepted beat.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;

    accept   = s_valid & i_enable;
    eff_col  = s_sof ? '0 : col_q;
    eff_row  = s_sof ? '0 : row_q;
    last_col = (eff_col == col_w_p'(hpixel_p - 1));
    last_row = (eff_row == row_w_p'(vpixel_p - 1));
    // Outside a frame only a start-of-frame beat is kept.
    take     = accept & (s_sof | (state_q == LOAD));

    if (!i_enable) begin
      // Disabling abandons any partial frame silently.
      state_d = WAIT_SOF;
      col_d   = '0;
      row_d   = '0;
    end else if (take) begin
      wr_en_d   = 1'b1;
      wr_data_d = s_data;
      wr_addr_d = addr_width_p'(eff_row) * addr_width_p'(hpixel_p)
                + addr_width_p'(eff_col);
      // A start-of-frame inside a frame is a resync: flagged but still loaded.
      err_d     = s_sof & (state_q == LOAD);

      if (s_eol != last_col) begin
        // Early or missing end-of-line: keep the beat, drop the frame.
        err_d   = 1'b1;
        state_d = WAIT_SOF;
        col_d   = '0;
        row_d   = '0;
      end else if (!last_col) begin
        col_d   = eff_col + col_w_p'(1);
        row_d   = eff_row;
        state_d = LOAD;
      end else if (!last_row) begin
        col_d   = '0;
        row_d   = eff_row + row_w_p'(1);
        state_d = LOAD;
      end else begin
        frame_done_d = 1'b1;
        state_d      = WAIT_SOF;
        col_d        = '0;
        row_d        = '0;
      end

      if (err_d && (err_cnt_q != 8'hff)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // State, counters and registered write port; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_SOF;
      col_q        <= '0;
      row_q        <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_wr_en      = wr_en_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;
  assign o_err_cnt    = err_cnt_q;

endmodule
